// File: rtl/inst_dispatcher_if.sv
// Dispatcher bundle: host control, PC fetch handshake,
// execution unit launch/done and status outputs.
interface inst_dispatcher_if #(
  parameter int INST_BITS = 128
);
  logic                 start;
  logic                 pc_flag;
  logic [INST_BITS-1:0] pc_inst;
  logic                 pc_inst_valid;
  logic [3:0]           unit_start;
  logic [3:0]           unit_done;
  logic [INST_BITS-5:0] operand;
  logic                 busy;
  logic                 halted;
  logic                 error;
  logic [1:0]           err_code;
  logic [31:0]          inst_count;

  modport master (
    input  start,
    input  pc_inst,
    input  pc_inst_valid,
    input  unit_done,
    output pc_flag,
    output unit_start,
    output operand,
    output busy,
    output halted,
    output error,
    output err_code,
    output inst_count
  );

  modport slave (
    output start,
    output pc_inst,
    output pc_inst_valid,
    output unit_done,
    input  pc_flag,
    input  unit_start,
    input  operand,
    input  busy,
    input  halted,
    input  error,
    input  err_code,
    input  inst_count
  );
endinterface

// File: rtl/inst_dispatcher.sv
// Instruction dispatcher: fetches from the PC, decodes the
// opcode and launches LOAD/COMPUTE/STORE/SYNC engines.
module inst_dispatcher #(
  parameter int INST_BITS      = 128,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic              clk,
  input logic              reset_n,
  inst_dispatcher_if.master bus
);

  localparam int OPW = INST_BITS - 4;
  localparam int TW  = (TIMEOUT_CYCLES < 2) ?
                       1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW:0] TLIM =
    (TW + 1)'(TIMEOUT_CYCLES);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [1:0] E_NONE = 2'd0;
  localparam logic [1:0] E_ILL  = 2'd1;
  localparam logic [1:0] E_EXH  = 2'd2;
  localparam logic [1:0] E_TMO  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_ISSUE,
    S_WAIT,
    S_HALTED,
    S_ERROR
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     err_q, err_d;
  logic [31:0]    cnt_q, cnt_d;
  logic [OPW-1:0] opnd_q, opnd_d;
  logic [3:0]     sel_q, sel_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           pc_flag_q;
  logic [3:0]     ustart_q;
  logic           busy_q;
  logic           halted_q;
  logic           error_q;

  logic [3:0]     opc;
  logic [OPW-1:0] opnd_in;
  logic [TW:0]    tmo_inc;
  logic           done_hit;

  assign opc      = bus.pc_inst[INST_BITS-1 -: 4];
  assign opnd_in  = bus.pc_inst[OPW-1:0];
  assign tmo_inc  = {1'b0, tmo_q} + {{TW{1'b0}}, 1'b1};
  assign done_hit = |(bus.unit_done & sel_q);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    sel_d   = sel_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      S_IDLE, S_HALTED: begin
        if (bus.start) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (!bus.pc_inst_valid) begin
          state_d = S_ERROR;
          err_d   = E_EXH;
        end else begin
          unique case (opc)
            4'h0: begin
              cnt_d   = cnt_q + 32'd1;
              state_d = S_FETCH;
            end
            4'hF: begin
              cnt_d   = cnt_q + 32'd1;
              state_d = S_HALTED;
            end
            4'h1, 4'h2, 4'h3, 4'h4: begin
              opnd_d  = opnd_in;
              sel_d   = 4'b0001 << (opc - 4'h1);
              state_d = S_ISSUE;
            end
            default: begin
              state_d = S_ERROR;
              err_d   = E_ILL;
            end
          endcase
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done on the limit cycle still retires
        if (done_hit) begin
          cnt_d   = cnt_q + 32'd1;
          state_d = S_FETCH;
        end else begin
          tmo_d = tmo_inc[TW-1:0];
          if (TMO_EN && tmo_inc == TLIM) begin
            state_d = S_ERROR;
            err_d   = E_TMO;
          end
        end
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      err_q     <= E_NONE;
      cnt_q     <= '0;
      opnd_q    <= '0;
      sel_q     <= '0;
      tmo_q     <= '0;
      pc_flag_q <= 1'b0;
      ustart_q  <= '0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      opnd_q    <= opnd_d;
      sel_q     <= sel_d;
      tmo_q     <= tmo_d;
      pc_flag_q <= (state_d == S_FETCH);
      ustart_q  <= (state_d == S_ISSUE) ?
                   sel_d : 4'b0000;
      busy_q    <= (state_d != S_IDLE) &&
                   (state_d != S_HALTED) &&
                   (state_d != S_ERROR);
      halted_q  <= (state_d == S_HALTED);
      error_q   <= (state_d == S_ERROR);
    end
  end

  assign bus.pc_flag    = pc_flag_q;
  assign bus.unit_start = ustart_q;
  assign bus.operand    = opnd_q;
  assign bus.busy       = busy_q;
  assign bus.halted     = halted_q;
  assign bus.error      = error_q;
  assign bus.err_code   = err_q;
  assign bus.inst_count = cnt_q;

endmodule

// File: tb/tb_inst_dispatcher.sv
// Directed bench for inst_dispatcher with a small PC
// and execution-unit responder model.
module tb_inst_dispatcher;

  localparam int IB = 128;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  inst_dispatcher_if #(.INST_BITS(IB)) bus ();

  inst_dispatcher #(
    .INST_BITS     (IB),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [IB-1:0] prog [16];
  int   pc;
  bit   pc_ok;
  bit   flag_prev;
  int   cyc_no;
  int   flags [$];
  int   starts;
  logic [3:0] last_mask;
  bit   auto_done;
  int   done_delay;
  int   done_timer;
  logic [3:0] done_mask;
  int   err_cyc;
  int   n;

  function automatic logic [IB-1:0] mk(
    input logic [3:0] op, input logic [31:0] v);
    logic [IB-1:0] w;
    w = '0;
    w[IB-1 -: 4] = op;
    w[31:0] = v;
    return w;
  endfunction

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // One clock: drive PC/unit responses, log outputs.
  task automatic cyc();
    @(negedge clk);
    cyc_no++;
    bus.start = 1'b0;
    bus.unit_done = 4'b0000;
    if (flag_prev) begin
      bus.pc_inst = prog[pc];
      bus.pc_inst_valid = pc_ok;
      pc++;
    end else begin
      bus.pc_inst_valid = 1'b0;
    end
    flag_prev = bus.pc_flag;
    if (done_timer > 0) begin
      done_timer--;
      if (done_timer == 0) bus.unit_done = done_mask;
    end
    if (bus.pc_flag) flags.push_back(cyc_no);
    if (bus.unit_start != 4'b0000) begin
      starts++;
      last_mask = bus.unit_start;
      if (auto_done) begin
        done_timer = done_delay;
        done_mask = bus.unit_start;
      end
    end
    if (bus.error && err_cyc < 0) err_cyc = cyc_no;
  endtask

  task automatic run(input int k);
    repeat (k) cyc();
  endtask

  task automatic clr();
    pc = 0;
    flag_prev = 1'b0;
    flags.delete();
    starts = 0;
    last_mask = '0;
    err_cyc = -1;
    done_timer = 0;
    cyc_no = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    run(2);
    reset_n = 1'b1;
    clr();
    pc_ok = 1'b1;
    for (int i = 0; i < 16; i++) prog[i] = mk(4'hF, 0);
  endtask

  task automatic go();
    flags.delete();
    starts = 0;
    err_cyc = -1;
    cyc_no = 0;
    bus.start = 1'b1;
  endtask

  task automatic wait_start();
    n = 0;
    while (starts == 0 && n < 20) begin
      cyc();
      n++;
    end
    chk("wait_unit_start", 128'(starts > 0), 1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.pc_inst = '0;
    bus.pc_inst_valid = 1'b0;
    bus.unit_done = 4'b0000;
    auto_done = 1'b1;
    done_delay = 4;
    clr();
    pc_ok = 1'b1;

    // reset values while reset held
    reset_n = 1'b0;
    run(3);
    chk("rst_pc_flag", bus.pc_flag, 0);
    chk("rst_ustart", bus.unit_start, 0);
    chk("rst_operand", bus.operand, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_errcode", bus.err_code, 0);
    chk("rst_count", bus.inst_count, 0);

    // LOAD 0x5, HALT
    do_reset();
    prog[0] = mk(4'h1, 32'h5);
    prog[1] = mk(4'hF, 0);
    done_delay = 4;
    go();
    run(3);
    chk("t1_busy_mid", bus.busy, 1);
    run(12);
    chk("t1_nflags", flags.size(), 2);
    chk("t1_flag0", flags[0], 1);
    chk("t1_flag1", flags[1], 8);
    chk("t1_nstarts", starts, 1);
    chk("t1_mask", last_mask, 4'b0001);
    chk("t1_operand", bus.operand, 128'h5);
    chk("t1_halted", bus.halted, 1);
    chk("t1_count", bus.inst_count, 2);
    chk("t1_busy", bus.busy, 0);

    // resume from HALTED at next address
    prog[2] = mk(4'hF, 0);
    go();
    run(6);
    chk("res_nflags", flags.size(), 1);
    chk("res_flag0", flags[0], 1);
    chk("res_halted", bus.halted, 1);
    chk("res_count", bus.inst_count, 3);

    // NOP x3, HALT
    do_reset();
    for (int i = 0; i < 3; i++) prog[i] = mk(4'h0, 0);
    prog[3] = mk(4'hF, 0);
    go();
    run(12);
    chk("nop_nflags", flags.size(), 4);
    chk("nop_f0", flags[0], 1);
    chk("nop_f1", flags[1], 3);
    chk("nop_f2", flags[2], 5);
    chk("nop_f3", flags[3], 7);
    chk("nop_starts", starts, 0);
    chk("nop_count", bus.inst_count, 4);
    chk("nop_halted", bus.halted, 1);

    // COMPUTE: done in ISSUE and wrong unit ignored
    do_reset();
    auto_done = 1'b0;
    prog[0] = mk(4'h2, 32'hA);
    prog[1] = mk(4'hF, 0);
    go();
    wait_start();
    chk("cmp_mask", last_mask, 4'b0010);
    bus.unit_done = 4'b0010;
    cyc();
    run(2);
    chk("cmp_busy", bus.busy, 1);
    bus.unit_done = 4'b0001;
    cyc();
    run(3);
    chk("cmp_nflags_wait", flags.size(), 1);
    bus.unit_done = 4'b0010;
    cyc();
    run(6);
    chk("cmp_nflags", flags.size(), 2);
    chk("cmp_flag1", flags[1], 11);
    chk("cmp_operand", bus.operand, 128'hA);
    chk("cmp_count", bus.inst_count, 2);
    chk("cmp_error", bus.error, 0);

    // STORE with no done: timeout after 8 cycles
    do_reset();
    prog[0] = mk(4'h3, 32'h7);
    go();
    run(20);
    chk("tmo_error", bus.error, 1);
    chk("tmo_code", bus.err_code, 3);
    chk("tmo_busy", bus.busy, 0);
    chk("tmo_cycle", err_cyc, 12);
    chk("tmo_mask", last_mask, 4'b0100);
    chk("tmo_nflags", flags.size(), 1);
    bus.start = 1'b1;
    run(10);
    chk("tmo_start_ign", flags.size(), 1);
    chk("tmo_sticky", bus.err_code, 3);

    // done on the limit cycle wins
    do_reset();
    auto_done = 1'b1;
    done_delay = 8;
    prog[0] = mk(4'h3, 32'h7);
    prog[1] = mk(4'hF, 0);
    go();
    run(20);
    chk("lim_error", bus.error, 0);
    chk("lim_flag1", flags[1], 12);
    chk("lim_halted", bus.halted, 1);
    chk("lim_count", bus.inst_count, 2);

    // SYNC launches bit3
    do_reset();
    done_delay = 1;
    prog[0] = mk(4'h4, 32'h3);
    go();
    run(10);
    chk("sync_mask", last_mask, 4'b1000);
    chk("sync_flag1", flags[1], 5);

    // illegal opcode after a NOP
    do_reset();
    prog[0] = mk(4'h0, 0);
    prog[1] = mk(4'h7, 0);
    go();
    run(10);
    chk("ill_error", bus.error, 1);
    chk("ill_code", bus.err_code, 1);
    chk("ill_count", bus.inst_count, 1);
    chk("ill_starts", starts, 0);

    // fetch not accepted
    do_reset();
    pc_ok = 1'b0;
    go();
    run(6);
    chk("exh_error", bus.error, 1);
    chk("exh_code", bus.err_code, 2);
    chk("exh_count", bus.inst_count, 0);

    // reset in the middle of WAIT_DONE
    do_reset();
    auto_done = 1'b0;
    prog[0] = mk(4'h1, 32'h9);
    go();
    wait_start();
    run(2);
    chk("mid_busy", bus.busy, 1);
    reset_n = 1'b0;
    cyc();
    chk("mid_busy_rst", bus.busy, 0);
    chk("mid_operand", bus.operand, 0);
    chk("mid_ustart", bus.unit_start, 0);
    chk("mid_flag", bus.pc_flag, 0);
    reset_n = 1'b1;
    run(6);
    chk("mid_nflags", flags.size(), 1);
    chk("mid_nstarts", starts, 1);
    clr();
    prog[0] = mk(4'hF, 0);
    go();
    run(6);
    chk("mid_restart_f0", flags[0], 1);
    chk("mid_restart_hlt", bus.halted, 1);
    chk("mid_restart_cnt", bus.inst_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
